// File: rtl/sram_axi_bridge_if.sv
// rtl/sram_axi_bridge_if.sv - SRAM-like CPU ports and AXI master signals of the bridge
interface sram_axi_bridge_if;
  // instruction fetch port
  logic        inst_sram_req;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  // data load/store port
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  // AXI read address / data
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  // AXI write address / data / response
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  // bridge side: serves the CPU ports and masters the AXI bus
  modport master (
    input  inst_sram_req, inst_sram_size, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
    input  data_sram_wstrb, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    output arid, araddr, arsize, arvalid,
    input  arready,
    input  rid, rdata, rvalid,
    output rready,
    output awaddr, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  // environment side: CPU stages plus the AXI slave
  modport slave (
    output inst_sram_req, inst_sram_size, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
    output data_sram_wstrb, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    input  arid, araddr, arsize, arvalid,
    output arready,
    output rid, rdata, rvalid,
    input  rready,
    input  awaddr, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - two SRAM-like CPU ports onto one AXI master, one read and one write outstanding
module sram_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input logic clk,
  input logic reset,
  sram_axi_bridge_if.master bus
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;

  r_state_t r_state;
  w_state_t w_state;

  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [2:0]  arsize_q;
  logic        arvalid_q;
  logic        rready_q;

  logic [31:0] awaddr_q;
  logic [2:0]  awsize_q;
  logic        awvalid_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        wvalid_q;
  logic        bready_q;

  logic data_rd_req;
  logic data_wr_req;
  logic data_rd_grant;
  logic inst_grant;
  logic wr_accept;
  logic serving_data_read;
  logic r_fire;
  logic b_fire;
  logic aw_done;
  logic w_done;

  assign data_rd_req = bus.data_sram_req & ~bus.data_sram_wr;
  assign data_wr_req = bus.data_sram_req &  bus.data_sram_wr;

  // A load must not overtake a store still in flight (RAW), so it waits for the write side to idle.
  assign data_rd_grant = (r_state == R_IDLE) & data_rd_req & (w_state == W_IDLE);
  // Fetch only loses to a load that is actually granted; a load held off by a store does not block it.
  assign inst_grant    = (r_state == R_IDLE) & bus.inst_sram_req & ~data_rd_grant;

  // A store must not overtake a load still in flight (WAR).
  assign serving_data_read = (r_state != R_IDLE) & (arid_q == DATA_ID);
  assign wr_accept         = (w_state == W_IDLE) & data_wr_req & ~serving_data_read;

  assign r_fire  = bus.rvalid & rready_q;
  assign b_fire  = bus.bvalid & bready_q;
  // A channel is done once its valid is already low or is being accepted this cycle.
  assign aw_done = ~awvalid_q | bus.awready;
  assign w_done  = ~wvalid_q  | bus.wready;

  assign bus.inst_sram_addr_ok = inst_grant;
  assign bus.data_sram_addr_ok = data_rd_grant | wr_accept;
  assign bus.inst_sram_data_ok = r_fire & (bus.rid == INST_ID);
  assign bus.data_sram_data_ok = (r_fire & (bus.rid == DATA_ID)) | b_fire;
  assign bus.inst_sram_rdata   = bus.rdata;
  assign bus.data_sram_rdata   = bus.rdata;

  assign bus.arid    = arid_q;
  assign bus.araddr  = araddr_q;
  assign bus.arsize  = arsize_q;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;
  assign bus.awaddr  = awaddr_q;
  assign bus.awsize  = awsize_q;
  assign bus.awvalid = awvalid_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;
  assign bus.wvalid  = wvalid_q;
  assign bus.bready  = bready_q;

  // Read FSM: grant one read, present it on AR, then wait for its single data beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= R_IDLE;
      arid_q    <= 4'd0;
      araddr_q  <= 32'd0;
      arsize_q  <= 3'd0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (data_rd_grant) begin
            arid_q    <= DATA_ID;
            araddr_q  <= bus.data_sram_addr;
            arsize_q  <= {1'b0, bus.data_sram_size};
            arvalid_q <= 1'b1;
            r_state   <= R_ADDR;
          end else if (inst_grant) begin
            arid_q    <= INST_ID;
            araddr_q  <= bus.inst_sram_addr;
            arsize_q  <= {1'b0, bus.inst_sram_size};
            arvalid_q <= 1'b1;
            r_state   <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (bus.rvalid) begin
            rready_q <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          r_state   <= R_IDLE;
        end
      endcase
    end
  end

  // Write FSM: AW and W handshake independently, then wait for the single B response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state   <= W_IDLE;
      awaddr_q  <= 32'd0;
      awsize_q  <= 3'd0;
      awvalid_q <= 1'b0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_accept) begin
            awaddr_q  <= bus.data_sram_addr;
            awsize_q  <= {1'b0, bus.data_sram_size};
            wdata_q   <= bus.data_sram_wdata;
            wstrb_q   <= bus.data_sram_wstrb;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            w_state   <= W_REQ;
          end
        end
        W_REQ: begin
          if (bus.awready) awvalid_q <= 1'b0;
          if (bus.wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            w_state  <= W_RESP;
          end
        end
        W_RESP: begin
          if (bus.bvalid) begin
            bready_q <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          w_state   <= W_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb/tb_sram_axi_bridge.sv - directed self-checking bench for sram_axi_bridge
module tb_sram_axi_bridge;
  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  sram_axi_bridge_if bus ();

  sram_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    bus.inst_sram_req   = 1'b0;
    bus.inst_sram_size  = 2'd2;
    bus.inst_sram_addr  = 32'd0;
    bus.data_sram_req   = 1'b0;
    bus.data_sram_wr    = 1'b0;
    bus.data_sram_size  = 2'd2;
    bus.data_sram_addr  = 32'd0;
    bus.data_sram_wstrb = 4'd0;
    bus.data_sram_wdata = 32'd0;
    bus.arready = 1'b0;
    bus.rid     = 4'd0;
    bus.rdata   = 32'd0;
    bus.rvalid  = 1'b0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
  endtask

  // inputs are changed at the falling edge; combinational outputs are sampled 1 ns later
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    clear_inputs();
    reset = 1'b1;
    cyc(); #1;
    check("rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
    check("rst_awvalid", {31'd0, bus.awvalid}, 32'd0);
    check("rst_wvalid",  {31'd0, bus.wvalid},  32'd0);
    check("rst_rready",  {31'd0, bus.rready},  32'd0);
    check("rst_bready",  {31'd0, bus.bready},  32'd0);
    check("rst_araddr",  bus.araddr, 32'd0);
    check("rst_data_ok", {30'd0, bus.inst_sram_data_ok, bus.data_sram_data_ok}, 32'd0);
    cyc(); reset = 1'b0;

    // ---- instruction read alone
    cyc(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1c000000; bus.arready = 1'b1; #1;
    check("t1_inst_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    check("t1_data_addr_ok", {31'd0, bus.data_sram_addr_ok}, 32'd0);
    cyc(); bus.inst_sram_req = 1'b0; #1;
    check("t1_arvalid", {31'd0, bus.arvalid}, 32'd1);
    check("t1_arid",    {28'd0, bus.arid},    32'd0);
    check("t1_araddr",  bus.araddr,           32'h1c000000);
    check("t1_arsize",  {29'd0, bus.arsize},  32'd2);
    check("t1_no_dok",  {31'd0, bus.inst_sram_data_ok}, 32'd0);
    cyc(); bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h02800c0c; #1;
    check("t1_rready",     {31'd0, bus.rready},            32'd1);
    check("t1_inst_dok",   {31'd0, bus.inst_sram_data_ok}, 32'd1);
    check("t1_inst_rdata", bus.inst_sram_rdata,            32'h02800c0c);
    check("t1_data_dok",   {31'd0, bus.data_sram_data_ok}, 32'd0);
    cyc(); bus.rvalid = 1'b0; #1;
    check("t1_rready_low", {31'd0, bus.rready},            32'd0);
    check("t1_dok_low",    {31'd0, bus.inst_sram_data_ok}, 32'd0);

    // ---- simultaneous instruction and data reads
    cyc();
    bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1c000004;
    bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b0; bus.data_sram_addr = 32'h1c001000; #1;
    check("t2_data_addr_ok", {31'd0, bus.data_sram_addr_ok}, 32'd1);
    check("t2_inst_held",    {31'd0, bus.inst_sram_addr_ok}, 32'd0);
    cyc(); bus.data_sram_req = 1'b0; #1;
    check("t2_arid_data", {28'd0, bus.arid}, 32'd1);
    check("t2_araddr",    bus.araddr,        32'h1c001000);
    check("t2_inst_held2", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
    cyc(); bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'h11223344; #1;
    check("t2_data_dok",   {31'd0, bus.data_sram_data_ok}, 32'd1);
    check("t2_data_rdata", bus.data_sram_rdata,            32'h11223344);
    check("t2_inst_no_dok", {31'd0, bus.inst_sram_data_ok}, 32'd0);
    check("t2_inst_held3", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
    cyc(); bus.rvalid = 1'b0; #1;
    check("t2_inst_granted", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    cyc(); bus.inst_sram_req = 1'b0; #1;
    check("t2_arid_inst", {28'd0, bus.arid}, 32'd0);
    check("t2_araddr2",   bus.araddr,        32'h1c000004);
    cyc(); bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'haabbccdd; #1;
    check("t2_inst_dok", {31'd0, bus.inst_sram_data_ok}, 32'd1);
    cyc(); bus.rvalid = 1'b0;

    // ---- store with awready delayed
    cyc();
    bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b1; bus.data_sram_addr = 32'h1c008000;
    bus.data_sram_wstrb = 4'hf; bus.data_sram_wdata = 32'hdeadbeef;
    bus.awready = 1'b0; bus.wready = 1'b1; #1;
    check("t3_addr_ok", {31'd0, bus.data_sram_addr_ok}, 32'd1);
    cyc(); bus.data_sram_req = 1'b0; #1;
    check("t3_awvalid1", {31'd0, bus.awvalid}, 32'd1);
    check("t3_wvalid1",  {31'd0, bus.wvalid},  32'd1);
    check("t3_awaddr",   bus.awaddr,           32'h1c008000);
    check("t3_wdata",    bus.wdata,            32'hdeadbeef);
    check("t3_wstrb",    {28'd0, bus.wstrb},   32'hf);
    check("t3_awsize",   {29'd0, bus.awsize},  32'd2);
    check("t3_bready0",  {31'd0, bus.bready},  32'd0);
    cyc(); #1;
    check("t3_wvalid_drop", {31'd0, bus.wvalid},  32'd0);
    check("t3_awvalid2",    {31'd0, bus.awvalid}, 32'd1);
    cyc(); bus.awready = 1'b1; #1;
    check("t3_awvalid3", {31'd0, bus.awvalid}, 32'd1);
    check("t3_bready1",  {31'd0, bus.bready},  32'd0);
    cyc(); bus.awready = 1'b0; #1;
    check("t3_awvalid_drop", {31'd0, bus.awvalid}, 32'd0);
    check("t3_bready_resp",  {31'd0, bus.bready},  32'd1);
    check("t3_no_dok",       {31'd0, bus.data_sram_data_ok}, 32'd0);
    cyc(); bus.bvalid = 1'b1; #1;
    check("t3_dok", {31'd0, bus.data_sram_data_ok}, 32'd1);
    cyc(); bus.bvalid = 1'b0; #1;
    check("t3_bready_low", {31'd0, bus.bready}, 32'd0);
    check("t3_dok_low",    {31'd0, bus.data_sram_data_ok}, 32'd0);

    // ---- load during outstanding store, concurrent fetch
    cyc();
    bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b1; bus.data_sram_addr = 32'h1c008004;
    bus.data_sram_wdata = 32'h01020304; bus.awready = 1'b1; bus.wready = 1'b1; bus.arready = 1'b1; #1;
    check("t4_store_ok", {31'd0, bus.data_sram_addr_ok}, 32'd1);
    cyc();
    bus.data_sram_wr = 1'b0;
    bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1c000008; #1;
    check("t4_load_held",  {31'd0, bus.data_sram_addr_ok}, 32'd0);
    check("t4_inst_grant", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    cyc(); bus.inst_sram_req = 1'b0; #1;
    check("t4_load_held2", {31'd0, bus.data_sram_addr_ok}, 32'd0);
    check("t4_arid_inst",  {28'd0, bus.arid},    32'd0);
    check("t4_bready",     {31'd0, bus.bready},  32'd1);
    cyc(); bus.bvalid = 1'b1; bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h0badf00d; #1;
    check("t4_store_dok",  {31'd0, bus.data_sram_data_ok}, 32'd1);
    check("t4_inst_dok",   {31'd0, bus.inst_sram_data_ok}, 32'd1);
    check("t4_load_held3", {31'd0, bus.data_sram_addr_ok}, 32'd0);
    cyc(); bus.bvalid = 1'b0; bus.rvalid = 1'b0; #1;
    check("t4_no_early_ar", {31'd0, bus.arvalid}, 32'd0);
    check("t4_load_ok",     {31'd0, bus.data_sram_addr_ok}, 32'd1);
    cyc(); bus.data_sram_req = 1'b0; #1;
    check("t4_arvalid", {31'd0, bus.arvalid}, 32'd1);
    check("t4_arid",    {28'd0, bus.arid},    32'd1);
    check("t4_araddr",  bus.araddr,           32'h1c008004);
    cyc(); bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'h00000055; #1;
    check("t4_load_dok",   {31'd0, bus.data_sram_data_ok}, 32'd1);
    check("t4_load_rdata", bus.data_sram_rdata,            32'h00000055);
    cyc(); clear_inputs();

    // ---- reset mid-transaction
    cyc();
    bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1c00000c;
    bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b1; bus.data_sram_addr = 32'h1c008008;
    bus.data_sram_wstrb = 4'h3; bus.arready = 1'b1; #1;
    check("t5_inst_ok",  {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    check("t5_store_ok", {31'd0, bus.data_sram_addr_ok}, 32'd1);
    cyc(); bus.inst_sram_req = 1'b0; bus.data_sram_req = 1'b0;
    cyc(); #1;
    check("t5_rready_pre",  {31'd0, bus.rready},  32'd1);
    check("t5_awvalid_pre", {31'd0, bus.awvalid}, 32'd1);
    #1 reset = 1'b1; #1;
    check("t5_rst_valids", {29'd0, bus.arvalid, bus.awvalid, bus.wvalid}, 32'd0);
    check("t5_rst_readies", {30'd0, bus.rready, bus.bready}, 32'd0);
    cyc(); bus.rvalid = 1'b1; bus.rid = 4'd0; bus.bvalid = 1'b1;
    cyc(); reset = 1'b0; #1;
    check("t5_no_dok", {30'd0, bus.inst_sram_data_ok, bus.data_sram_data_ok}, 32'd0);
    cyc(); #1;
    check("t5_no_dok2", {30'd0, bus.inst_sram_data_ok, bus.data_sram_data_ok}, 32'd0);
    cyc(); bus.rvalid = 1'b0; bus.bvalid = 1'b0;
    bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h1c000010; bus.arready = 1'b1; #1;
    check("t5_fresh_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    cyc(); bus.inst_sram_req = 1'b0; #1;
    check("t5_fresh_araddr", bus.araddr, 32'h1c000010);
    check("t5_fresh_arvalid", {31'd0, bus.arvalid}, 32'd1);
    cyc(); clear_inputs();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Converts the CPU's two SRAM-like request ports (instruction fetch, data load/store) into a single AXI master, sharing one read channel and one write channel between them. It sits between the IF/MEM stages and the top-level AXI wrapper, one level below the core top. It arbitrates read requests, keeps one read and one write outstanding, and holds off data-port requests that could reorder memory accesses. Remaining AXI fields (len=0, burst=INCR, lock/cache/prot=0, wid=1) are tied off in the wrapper.

## Interface
Parameters:
- INST_ID, 4'd0, arid used for instruction reads
- DATA_ID, 4'd1, arid/awid used for data reads and writes

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- inst_sram_req / inst_sram_size / inst_sram_addr  in  1/2/32  fetch request; read-only (inst_sram_wr ignored)
- inst_sram_addr_ok / inst_sram_data_ok  out  1/1  request accepted / read data returned
- inst_sram_rdata  out  32  fetch data
- data_sram_req / data_sram_wr / data_sram_size  in  1/1/2  data request, write flag, log2 bytes
- data_sram_addr / data_sram_wstrb / data_sram_wdata  in  32/4/32  address, byte strobes, store data
- data_sram_addr_ok / data_sram_data_ok  out  1/1  accepted / completed (load data or store response)
- data_sram_rdata  out  32  load data
- arid / araddr / arsize / arvalid  out  4/32/3/1  AXI read address
- arready  in  1
- rid / rdata / rvalid  in  4/32/1  AXI read data
- rready  out  1
- awaddr / awsize / awvalid  out  32/3/1  AXI write address
- awready  in  1
- wdata / wstrb / wvalid  out  32/4/1  AXI write data
- wready  in  1
- bvalid  in  1
- bready  out  1

## Operation
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_IDLE grants a read: data read (data_sram_req & ~data_sram_wr) beats inst read.
  - Data read granted only if write FSM is W_IDLE (RAW ordering).
  - On grant: pulse the winner's addr_ok, latch addr, {1'b0,size} and id into ar* registers, go R_ADDR.
  - R_ADDR: arvalid=1; on arready go R_DATA.
  - R_DATA: rready=1; on rvalid, route to the port given by rid, then go R_IDLE.
- Write FSM: W_IDLE -> W_REQ -> W_RESP -> W_IDLE.
  - W_IDLE accepts a data write (data_sram_req & data_sram_wr) unless the read FSM is serving a data read (WAR ordering).
  - On accept: pulse data_sram_addr_ok, latch aw*/w* fields, set awvalid=wvalid=1.
  - W_REQ: awvalid and wvalid each drop independently on their own ready; go W_RESP once both handshakes have happened, in either order or the same cycle.
  - W_RESP: bready=1; on bvalid, pulse data_sram_data_ok and go W_IDLE.
- Instruction reads may proceed concurrently with an outstanding write.
- data_sram_addr_ok never pulses for a read and a write in the same cycle; the single req/wr pair rules it out.
- rresp and bresp are ignored.

## Timing
- Reset: both FSMs idle; arvalid, awvalid, wvalid, rready, bready, addr_ok, data_ok all 0; latched fields 0. Reset in mid-transaction abandons it; no data_ok is produced afterwards.
- addr_ok is combinational, in the same cycle as req, when the grant condition holds. arvalid/awvalid/wvalid are registered and rise the following cycle.
- data_ok is a one-cycle combinational pulse: rvalid & rready for reads, bvalid & bready for writes. rdata passes straight through on the data_ok cycle.
- Minimum read latency with arready and rvalid always high: req cycle T, arvalid at T+1, rvalid/data_ok at T+2 or later. The next grant is possible at T+3 (R_IDLE).
- A read and a write may complete in the same cycle on different ports.

## Test plan
- Inst read alone: inst req addr 0x1c000000, arready=1, rvalid with rdata 0x02800c0c two cycles later -> addr_ok at T, arid=0, araddr=0x1c000000, arsize=2, inst_sram_data_ok with rdata 0x02800c0c; data_sram_data_ok stays 0.
- Simultaneous inst and data read requests -> data granted first (arid=1); inst_sram_addr_ok held 0 until read FSM returns to R_IDLE, then inst granted.
- Store sw 0x1c008000 wstrb 0xf with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid after 3; bready only in W_RESP; a single data_sram_data_ok pulse on bvalid.
- Load issued during an outstanding store -> data_sram_addr_ok=0 until bvalid; the load's arvalid never precedes bvalid. An inst read in the same window is granted.
- Reset asserted in R_DATA and W_REQ -> all valids/readies 0 immediately (async); no data_ok after reset release; a fresh request is accepted normally.
